// File: rtl/tmds_pkg.sv
// Shared TMDS receive types: control token table, symbol type, alignment states.
// Pure declarations; no timing and no flow control.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // Index is the {c1,c0} value the token carries.
    localparam tmds_sym_t CTRL_TOKEN [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol to {data, ctrl, is_token}; zero latency, no backpressure.
// Also used standalone as a checker on the encoder side.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  tmds_sym_t  i_sym,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_is_token
);

    logic [7:0] w_d;

    always_comb begin
        w_d        = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        o_data     = 8'h00;
        o_ctrl     = 2'b00;
        o_is_token = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i_sym == CTRL_TOKEN[i]) begin
                o_is_token = 1'b1;
                o_ctrl     = 2'(i);
            end
        end
        // sym[8] records whether the encoder chained with XOR (1) or XNOR (0)
        if (!o_is_token) begin
            o_data[0] = w_d[0];
            for (int i = 1; i < 8; i++) begin
                o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: token-hunting word alignment plus symbol decode; optional TMDS_DISPARITY_CHECK_EN.
// Latency 2 clk from the aligned window to data/ctrl/blank; no backpressure, runs at pixel rate.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_raw_word,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_blank,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_disp_err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_LAST   = RW'(LOCK_COUNT - 1);
    localparam logic [RW-1:0] RUN_MAX    = RW'(LOCK_COUNT);

    tmds_sym_t     r_raw_prev;
    tmds_sym_t     r_sym;
    logic [19:0]   w_win;
    logic [7:0]    w_data;
    logic [1:0]    w_ctrl;
    logic          w_is_token;
    align_state_t  r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_run;

    assign w_win = {i_raw_word, r_raw_prev};

    tmds_symbol_decode u_decode (
        .i_sym      (r_sym),
        .o_data     (w_data),
        .o_ctrl     (w_ctrl),
        .o_is_token (w_is_token)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_raw_prev <= '0;
            r_sym      <= '0;
            o_data     <= 8'h00;
            o_ctrl     <= 2'b00;
            o_blank    <= 1'b1;
        end else begin
            r_raw_prev <= i_raw_word;
            r_sym      <= 10'(w_win >> o_offset);
            o_data     <= w_data;
            o_blank    <= w_is_token;
            if (w_is_token) begin
                o_ctrl <= w_ctrl;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= SEARCH;
            r_timer  <= '0;
            r_run    <= '0;
            o_locked <= 1'b0;
            o_offset <= 4'd0;
        end else begin
            case (r_state)
                SEARCH: begin
                    // Lock is checked first so it wins over a coincident timeout
                    if (w_is_token && r_run == RUN_LAST) begin
                        r_state  <= LOCKED;
                        o_locked <= 1'b1;
                        r_timer  <= '0;
                        r_run    <= RUN_MAX;
                    end else if (r_timer == TIMER_LAST) begin
                        o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
                        r_timer  <= '0;
                        r_run    <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if (!w_is_token) begin
                            r_run <= '0;
                        end else if (r_run != RUN_MAX) begin
                            r_run <= r_run + RW'(1);
                        end
                    end
                end
                default: begin
                    if (w_is_token) begin
                        r_timer <= '0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state  <= SEARCH;
                        o_locked <= 1'b0;
                        r_timer  <= '0;
                        r_run    <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
            endcase
        end
    end

`ifdef TMDS_DISPARITY_CHECK_EN
    logic signed [4:0] r_disp;
    logic signed [4:0] w_delta;
    logic signed [5:0] w_sum;
    logic              w_viol;

    // (ones - zeros)/2 over 10 bits is ones - 5
    always_comb begin
        w_delta = 5'($countones(r_sym) - 5);
        w_sum   = 6'(r_disp) + 6'(w_delta);
        w_viol  = (w_sum > 6'sd4) || (w_sum < -6'sd4);
    end

    // Clearing after a violation re-arms the check so each excursion is one pulse
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_disp     <= '0;
            o_disp_err <= 1'b0;
        end else begin
            o_disp_err <= 1'b0;
            if (w_is_token || !o_locked) begin
                r_disp <= '0;
            end else if (w_viol) begin
                r_disp     <= '0;
                o_disp_err <= 1'b1;
            end else begin
                r_disp <= w_sum[4:0];
            end
        end
    end
`else
    assign o_disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: alignment search, symbol decode, timeout/relock, async reset.
module tb_tmds_decoder;
    import tmds_pkg::*;

    localparam int LOCK_COUNT = 16;
    localparam int TIMEOUT    = 1024;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       blank;
    } exp_t;

    localparam exp_t TOK0 = {8'h00, 2'b00, 1'b1};
    localparam exp_t TOK1 = {8'h00, 2'b01, 1'b1};
    localparam exp_t TOK2 = {8'h00, 2'b10, 1'b1};
    localparam exp_t TOK3 = {8'h00, 2'b11, 1'b1};

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] raw_word = 10'h000;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       blank;
    logic       locked;
    logic [3:0] offset;
    logic       disp_err;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    tmds_decoder #(
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_raw_word (raw_word),
        .o_data     (data),
        .o_ctrl     (ctrl),
        .o_blank    (blank),
        .o_locked   (locked),
        .o_offset   (offset),
        .o_disp_err (disp_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [9:0] w);
        raw_word = w;
        @(posedge clk);
        #1;
    endtask

    // Reference TMDS encoder; the inversion bit is free because the decoder must undo either choice
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
        logic [8:0] qm;
        logic       use_xnor;
        int         n1;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && !d[0]);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (data !== 8'h00)  begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
        n_vec++; if (ctrl !== 2'b00)  begin n_err++; $display("FAIL reset_ctrl: got %b want 00", ctrl); end
        n_vec++; if (blank !== 1'b1)  begin n_err++; $display("FAIL reset_blank: got %b want 1", blank); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_vec++; if (offset !== 4'd0) begin n_err++; $display("FAIL reset_offset: got %0d want 0", offset); end
        n_vec++; if (disp_err !== 1'b0) begin n_err++; $display("FAIL reset_disp_err: got %b want 0", disp_err); end
        @(negedge clk) reset = 1'b1;
    endtask

    // Token stream arriving 3 bits late: raw word is the token rotated left by 3
    task automatic test_phase_lock();
        logic [9:0] tok;
        logic [9:0] w;
        logic       got;
        tok = 10'h354;
        w   = (tok << 3) | (tok >> 7);
        got = 1'b0;
        for (int i = 0; i < 10 * TIMEOUT + LOCK_COUNT + 2 && !got; i++) begin
            step(w);
            if (locked === 1'b1) got = 1'b1;
        end
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL phase_lock: locked got %b want 1 within budget", locked); end
        n_vec++; if (offset !== 4'd3) begin n_err++; $display("FAIL phase_offset: got %0d want 3", offset); end
        step(w);
        step(w);
        n_vec++;
        if ({data, ctrl, blank} !== TOK0) begin
            n_err++;
            $display("FAIL phase_token: got data=%h ctrl=%b blank=%b want 00/00/1", data, ctrl, blank);
        end
    endtask

    task automatic test_reset_midstream();
        int first;
        step(10'h354);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (data !== 8'h00)  begin n_err++; $display("FAIL areset_data: got %h want 00", data); end
        n_vec++; if (ctrl !== 2'b00)  begin n_err++; $display("FAIL areset_ctrl: got %b want 00", ctrl); end
        n_vec++; if (blank !== 1'b1)  begin n_err++; $display("FAIL areset_blank: got %b want 1", blank); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL areset_locked: got %b want 0", locked); end
        n_vec++; if (offset !== 4'd0) begin n_err++; $display("FAIL areset_offset: got %0d want 0", offset); end
        n_vec++; if (disp_err !== 1'b0) begin n_err++; $display("FAIL areset_disp_err: got %b want 0", disp_err); end
        raw_word = 10'h354;
        @(negedge clk) reset = 1'b1;
        // Aligned tokens: one clk into raw_prev, one into stage 1, then LOCK_COUNT counted
        first = 0;
        for (int i = 1; i <= LOCK_COUNT + 6; i++) begin
            step(10'h354);
            if (locked === 1'b1 && first == 0) first = i;
        end
        n_vec++; if (first != LOCK_COUNT + 2) begin n_err++; $display("FAIL relock_after_reset: lock at cycle %0d want %0d", first, LOCK_COUNT + 2); end
        n_vec++; if (offset !== 4'd0) begin n_err++; $display("FAIL relock_offset: got %0d want 0", offset); end
    endtask

    // Aligned words reach the outputs 3 clk after being driven (raw_prev, stage 1, stage 2)
    task automatic test_data_decode();
        logic [9:0] w [9];
        exp_t       x [9];
        exp_t       e;
        w = '{10'h354, 10'h354, 10'h100, 10'h200, 10'h100, 10'h200, 10'h354, 10'h354, 10'h354};
        x = '{TOK0, TOK0, {8'h00, 2'b00, 1'b0}, {8'hFF, 2'b00, 1'b0},
              {8'h00, 2'b00, 1'b0}, {8'hFF, 2'b00, 1'b0}, TOK0, TOK0, TOK0};
        sb_q.delete();
        for (int k = 0; k < 9; k++) begin
            sb_q.push_back(x[k]);
            step(w[k]);
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({data, ctrl, blank} !== e) begin
                    n_err++;
                    $display("FAIL data_decode: got data=%h ctrl=%b blank=%b want data=%h ctrl=%b blank=%b",
                             data, ctrl, blank, e.data, e.ctrl, e.blank);
                end
            end
        end
    endtask

    task automatic test_ctrl_tokens();
        logic [9:0] w [8];
        exp_t       x [8];
        exp_t       e;
        w = '{10'h0AB, 10'h0AB, 10'h154, 10'h2AB, 10'h100, 10'h354, 10'h354, 10'h354};
        x = '{TOK1, TOK1, TOK2, TOK3, {8'h00, 2'b11, 1'b0}, TOK0, TOK0, TOK0};
        sb_q.delete();
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back(x[k]);
            step(w[k]);
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({data, ctrl, blank} !== e) begin
                    n_err++;
                    $display("FAIL ctrl_tokens: got data=%h ctrl=%b blank=%b want data=%h ctrl=%b blank=%b",
                             data, ctrl, blank, e.data, e.ctrl, e.blank);
                end
            end
        end
    endtask

    task automatic test_random_data();
        logic [7:0] b;
        logic [9:0] w;
        exp_t       x;
        exp_t       e;
        sb_q.delete();
        for (int k = 0; k < 46; k++) begin
            if (k < 3 || k >= 43) begin
                w = 10'h354;
                x = TOK0;
            end else begin
                b = 8'($urandom_range(255));
                w = tmds_enc(b, 1'($urandom_range(1)));
                x = {b, 2'b00, 1'b0};
            end
            sb_q.push_back(x);
            step(w);
            if (sb_q.size() == 3) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({data, ctrl, blank} !== e) begin
                    n_err++;
                    $display("FAIL random_data: got data=%h ctrl=%b blank=%b want data=%h ctrl=%b blank=%b",
                             data, ctrl, blank, e.data, e.ctrl, e.blank);
                end
            end
        end
    endtask

    // First data word reaches stage 1 at cycle 2, so the drop lands TIMEOUT cycles later
    task automatic test_timeout_relock();
        int drop;
        int relock;
        repeat (4) step(10'h354);
        drop = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            step(10'h100);
            if (locked === 1'b0 && drop == 0) drop = i;
        end
        n_vec++; if (drop != TIMEOUT + 2) begin n_err++; $display("FAIL timeout_drop: dropped at cycle %0d want %0d", drop, TIMEOUT + 2); end
        n_vec++; if (offset !== 4'd0) begin n_err++; $display("FAIL timeout_offset: got %0d want 0", offset); end
        relock = 0;
        for (int i = 1; i <= LOCK_COUNT + 6; i++) begin
            step(10'h354);
            if (locked === 1'b1 && relock == 0) relock = i;
        end
        n_vec++; if (relock != LOCK_COUNT + 2) begin n_err++; $display("FAIL timeout_relock: lock at cycle %0d want %0d", relock, LOCK_COUNT + 2); end
        n_vec++; if (offset !== 4'd0) begin n_err++; $display("FAIL relock_offset2: got %0d want 0", offset); end
    endtask

    task automatic test_disparity();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step((k >= 2 && k < 7) ? 10'h200 : 10'h354);
            if (disp_err === 1'b1) pulses++;
        end
`ifdef TMDS_DISPARITY_CHECK_EN
        n_vec++; if (pulses < 1) begin n_err++; $display("FAIL disparity: got %0d pulses want at least 1", pulses); end
`else
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL disparity_off: got %0d pulses want 0", pulses); end
`endif
    endtask

    initial begin
        test_reset();
        test_phase_lock();
        test_reset_midstream();
        test_data_decode();
        test_ctrl_tokens();
        test_random_data();
        test_timeout_relock();
        test_disparity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
